// File: rtl/radix_conv_pkg.sv
// Shared types and constants for the radix string-to-binary converter.
package radix_conv_pkg;

  localparam int unsigned CHAR_W  = 8;
  localparam int unsigned BASE_W  = 6;
  localparam int unsigned DIGIT_W = 6;
  localparam int unsigned ERR_W   = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

  typedef enum logic [ERR_W-1:0] {
    ERR_NONE = 3'd0,
    ERR_BASE = 3'd1,
    ERR_CHAR = 3'd2,
    ERR_LONG = 3'd3,
    ERR_OVF  = 3'd4
  } err_e;

  // Sticky per-string error flags; base errors never reach the accumulate phase.
  typedef struct packed {
    logic chr;
    logic lng;
    logic ovf;
  } err_flags_t;

  localparam logic [BASE_W-1:0] MIN_BASE = 6'd2;
  localparam logic [BASE_W-1:0] MAX_BASE = 6'd36;

  localparam logic [CHAR_W-1:0] ASCII_0     = 8'h30;
  localparam logic [CHAR_W-1:0] ASCII_9     = 8'h39;
  localparam logic [CHAR_W-1:0] ASCII_UA    = 8'h41;
  localparam logic [CHAR_W-1:0] ASCII_UZ    = 8'h5A;
  localparam logic [CHAR_W-1:0] ASCII_LA    = 8'h61;
  localparam logic [CHAR_W-1:0] ASCII_LZ    = 8'h7A;
  localparam logic [CHAR_W-1:0] ASCII_MINUS = 8'h2D;

  // Collapse sticky flags into the single reported code, highest priority first.
  function automatic err_e err_pick(input err_flags_t f);
    err_e e;
    e = ERR_NONE;
    if (f.chr)      e = ERR_CHAR;
    else if (f.lng) e = ERR_LONG;
    else if (f.ovf) e = ERR_OVF;
    return e;
  endfunction

endpackage

// File: rtl/radix_stream_to_binary_decode.sv
// ASCII character to digit value, qualified against the active radix.
module radix_digit_decode
  import radix_conv_pkg::*;
(
  input  logic [CHAR_W-1:0]  ch_data,
  input  logic [BASE_W-1:0]  base,
  output logic [DIGIT_W-1:0] digit,
  output logic               digit_ok
);

  logic is_sym;

  always_comb begin
    digit    = '0;
    is_sym   = 1'b0;
    digit_ok = 1'b0;
    if (ch_data >= ASCII_0 && ch_data <= ASCII_9) begin
      digit  = DIGIT_W'(ch_data - ASCII_0);
      is_sym = 1'b1;
    end else if (ch_data >= ASCII_UA && ch_data <= ASCII_UZ) begin
      digit  = DIGIT_W'(ch_data - ASCII_UA + 8'd10);
      is_sym = 1'b1;
    end else if (ch_data >= ASCII_LA && ch_data <= ASCII_LZ) begin
      digit  = DIGIT_W'(ch_data - ASCII_LA + 8'd10);
      is_sym = 1'b1;
    end
    digit_ok = is_sym && (digit < base);
  end

endmodule

// File: rtl/radix_stream_to_binary.sv
// Streaming ASCII radix-2..36 string to binary converter, one character per cycle.
// Define RADIX_CONV_SIGN_EN to accept a leading '-' and produce two's-complement results.
module radix_stream_to_binary
  import radix_conv_pkg::*;
#(
  parameter int unsigned VAL_W      = 32,
  parameter int unsigned MAX_DIGITS = 16,
  parameter int unsigned CNT_W      = $clog2(MAX_DIGITS + 2)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [BASE_W-1:0] base_in,
  input  logic              ch_valid,
  input  logic [CHAR_W-1:0] ch_data,
  input  logic              ch_last,
  output logic              ch_ready,
  output logic              res_valid,
  output logic [VAL_W-1:0]  res_value,
  output logic [ERR_W-1:0]  res_err,
  input  logic              res_ready,
  output logic              busy
);

  localparam int unsigned EXT_W = VAL_W + 6;

  state_e             state_q, state_d;
  logic [BASE_W-1:0]  base_q, base_d;
  logic [VAL_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  err_flags_t         flags_q, flags_d;
  logic [VAL_W-1:0]   res_value_q, res_value_d;
  err_e               res_err_q, res_err_d;
  logic               ch_ready_q, res_valid_q, busy_q;

  logic [DIGIT_W-1:0] digit;
  logic               digit_ok;
  logic               beat;
  logic               sign_beat;
  logic [EXT_W-1:0]   prod;
  err_e               fin_err;

`ifdef RADIX_CONV_SIGN_EN
  localparam logic [VAL_W-1:0] NEG_LIM = {1'b1, {(VAL_W-1){1'b0}}};
  logic neg_q, neg_d, first_q, first_d;
`endif

  radix_digit_decode u_decode (
    .ch_data  (ch_data),
    .base     (base_q),
    .digit    (digit),
    .digit_ok (digit_ok)
  );

  // ch_ready_q is high exactly while in ACCUM, so it qualifies the beat on its own.
  assign beat = ch_valid & ch_ready_q;

  // Next-state, accumulate and result capture.
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    flags_d     = flags_q;
    res_value_d = res_value_q;
    res_err_d   = res_err_q;
    sign_beat   = 1'b0;
    prod        = '0;
    fin_err     = ERR_NONE;
`ifdef RADIX_CONV_SIGN_EN
    neg_d       = neg_q;
    first_d     = first_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          base_d  = base_in;
          acc_d   = '0;
          cnt_d   = '0;
          flags_d = '0;
`ifdef RADIX_CONV_SIGN_EN
          neg_d   = 1'b0;
          first_d = 1'b1;
`endif
          if (base_in < MIN_BASE || base_in > MAX_BASE) begin
            state_d     = DONE;
            res_err_d   = ERR_BASE;
            res_value_d = '0;
          end else begin
            state_d = ACCUM;
          end
        end
      end
      ACCUM: begin
        if (beat) begin
`ifdef RADIX_CONV_SIGN_EN
          first_d = 1'b0;
          if (first_q && ch_data == ASCII_MINUS) begin
            sign_beat = 1'b1;
            neg_d     = 1'b1;
          end
`endif
          if (!sign_beat) begin
            if (cnt_q != CNT_W'(MAX_DIGITS + 1)) cnt_d = cnt_q + CNT_W'(1);
            if (cnt_d == CNT_W'(MAX_DIGITS + 1)) flags_d.lng = 1'b1;
            if (digit_ok) begin
              prod = EXT_W'(acc_q) * EXT_W'(base_q) + EXT_W'(digit);
              if (|prod[EXT_W-1:VAL_W]) flags_d.ovf = 1'b1;
              acc_d = prod[VAL_W-1:0];
            end else begin
              flags_d.chr = 1'b1;
            end
          end
          if (ch_last) begin
            state_d = DONE;
`ifdef RADIX_CONV_SIGN_EN
            // A sign with no digits is malformed; magnitude limits differ by sign.
            if (neg_d && cnt_d == '0) flags_d.chr = 1'b1;
            if (neg_d ? (acc_d > NEG_LIM) : acc_d[VAL_W-1]) flags_d.ovf = 1'b1;
`endif
            fin_err     = err_pick(flags_d);
            res_err_d   = fin_err;
            res_value_d = '0;
            if (fin_err == ERR_NONE) begin
`ifdef RADIX_CONV_SIGN_EN
              res_value_d = neg_d ? (~acc_d + VAL_W'(1)) : acc_d;
`else
              res_value_d = acc_d;
`endif
            end
          end
        end
      end
      DONE: begin
        if (res_ready) begin
          state_d     = IDLE;
          res_value_d = '0;
          res_err_d   = ERR_NONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, datapath and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      base_q      <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      flags_q     <= '0;
      res_value_q <= '0;
      res_err_q   <= ERR_NONE;
      ch_ready_q  <= 1'b0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      flags_q     <= flags_d;
      res_value_q <= res_value_d;
      res_err_q   <= res_err_d;
      ch_ready_q  <= (state_d == ACCUM);
      res_valid_q <= (state_d == DONE);
      busy_q      <= (state_d != IDLE);
    end
  end

`ifdef RADIX_CONV_SIGN_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_q   <= 1'b0;
      first_q <= 1'b0;
    end else begin
      neg_q   <= neg_d;
      first_q <= first_d;
    end
  end
`endif

  assign ch_ready  = ch_ready_q;
  assign res_valid = res_valid_q;
  assign res_value = res_value_q;
  assign res_err   = res_err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_radix_stream_to_binary.sv
// Self-checking bench: directed cases plus random strings against an arithmetic reference model.
module tb_radix_stream_to_binary;
  import radix_conv_pkg::*;

  localparam int unsigned VW = 32;
  localparam int unsigned MD = 16;

  typedef logic [7:0] bq_t[$];

  logic          clk       = 1'b0;
  logic          rst_n     = 1'b0;
  logic          start     = 1'b0;
  logic [5:0]    base_in   = '0;
  logic          ch_valid  = 1'b0;
  logic [7:0]    ch_data   = '0;
  logic          ch_last   = 1'b0;
  logic          ch_ready;
  logic          res_valid;
  logic [VW-1:0] res_value;
  logic [2:0]    res_err;
  logic          res_ready = 1'b0;
  logic          busy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  radix_stream_to_binary #(.VAL_W(VW), .MAX_DIGITS(MD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_in   (base_in),
    .ch_valid  (ch_valid),
    .ch_data   (ch_data),
    .ch_last   (ch_last),
    .ch_ready  (ch_ready),
    .res_valid (res_valid),
    .res_value (res_value),
    .res_err   (res_err),
    .res_ready (res_ready),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic bq_t str2q(input string s);
    bq_t q;
    q = {};
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    return q;
  endfunction

  function automatic int digit_of(input logic [7:0] c);
    if (c >= "0" && c <= "9") return int'(c) - 48;
    if (c >= "A" && c <= "Z") return int'(c) - 55;
    if (c >= "a" && c <= "z") return int'(c) - 87;
    return -1;
  endfunction

  // Reference: true numeric value of the string, overflow judged against the range.
  function automatic void model(input int base, input bq_t s,
                                output logic [63:0] val, output logic [2:0] err);
    longint unsigned lim;
    longint unsigned mag;
    bit neg, bad, ovf;
    int n, d;
    lim = 64'd1 << VW;
    mag = 0; neg = 0; bad = 0; ovf = 0; n = 0;
    val = '0;
    err = ERR_NONE;
    if (base < 2 || base > 36) begin
      err = ERR_BASE;
      return;
    end
    for (int i = 0; i < s.size(); i++) begin
`ifdef RADIX_CONV_SIGN_EN
      if (i == 0 && s[i] == 8'h2D) begin
        neg = 1;
        continue;
      end
`endif
      n++;
      d = digit_of(s[i]);
      if (d < 0 || d >= base) bad = 1;
      else if (!ovf) begin
        mag = mag * 64'(base) + 64'(d);
        if (mag >= lim) ovf = 1;
      end
    end
`ifdef RADIX_CONV_SIGN_EN
    if (neg && n == 0) bad = 1;
    if (!ovf && (neg ? (mag > (lim >> 1)) : (mag >= (lim >> 1)))) ovf = 1;
`endif
    if (bad)          err = ERR_CHAR;
    else if (n > MD)  err = ERR_LONG;
    else if (ovf)     err = ERR_OVF;
    else begin
      err = ERR_NONE;
      val = neg ? ((lim - mag) & (lim - 1)) : mag;
    end
  endfunction

  function automatic bq_t gen(input int base);
    bq_t q;
    int len, r, d;
    q = {};
    len = ($urandom_range(0, 4) == 0) ? $urandom_range(1, MD + 2) : $urandom_range(1, 8);
    for (int i = 0; i < len; i++) begin
      r = $urandom_range(0, 99);
      if (i == 0 && r < 10) q.push_back(8'h2D);
      else if (r < 15) q.push_back(8'($urandom_range(32, 126)));
      else begin
        d = $urandom_range(0, base - 1);
        if (d < 10)             q.push_back(8'(48 + d));
        else if (r % 2 == 0)    q.push_back(8'(55 + d));
        else                    q.push_back(8'(87 + d));
      end
    end
    return q;
  endfunction

  task automatic run_string(input int base, input bq_t s, input logic [63:0] exp_val,
                            input logic [2:0] exp_err, input int hold, input bit keep_ready);
    int t;
    res_ready = keep_ready;
    start     = 1'b1;
    base_in   = 6'(base);
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1);
    if (exp_err == ERR_BASE) begin
      check("ch_ready_base", ch_ready, 0);
    end else begin
      for (int i = 0; i < s.size(); i++) begin
        if ($urandom_range(0, 3) == 0) begin
          ch_valid = 1'b0;
          @(negedge clk);
        end
        ch_valid = 1'b1;
        ch_data  = s[i];
        ch_last  = (i == s.size() - 1);
        t = 0;
        while (!ch_ready && t < 20) begin
          @(negedge clk);
          t++;
        end
        if (!ch_ready) begin
          check("ch_ready_timeout", 0, 1);
          break;
        end
        if (ch_last) check("res_valid_early", res_valid, 0);
        @(negedge clk);
      end
      ch_valid = 1'b0;
      ch_last  = 1'b0;
      ch_data  = '0;
    end
    check("res_valid", res_valid, 1);
    check("res_value", res_value, exp_val);
    check("res_err", res_err, exp_err);
    if (!keep_ready) begin
      for (int k = 0; k < hold; k++) begin
        start    = 1'($urandom_range(0, 1));
        base_in  = 6'd10;
        ch_valid = 1'($urandom_range(0, 1));
        ch_data  = 8'h31;
        @(negedge clk);
        check("hold_valid", res_valid, 1);
        check("hold_value", res_value, exp_val);
        check("hold_err", res_err, exp_err);
        check("hold_ch_ready", ch_ready, 0);
      end
      start     = 1'b0;
      ch_valid  = 1'b0;
      ch_data   = '0;
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
    end else begin
      @(negedge clk);
    end
    check("idle_busy", busy, 0);
    check("idle_valid", res_valid, 0);
  endtask

  task automatic run_model(input int base, input bq_t s, input int hold, input bit keep_ready);
    logic [63:0] ev;
    logic [2:0]  ee;
    model(base, s, ev, ee);
    run_string(base, s, ev, ee, hold, keep_ready);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    repeat (2) @(negedge clk);
    check("rst_ch_ready", ch_ready, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_value", res_value, 0);
    check("rst_res_err", res_err, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_string(2,  str2q("1010"), 64'd10,   ERR_NONE, 0, 1'b0);
    run_string(16, str2q("7F"),   64'd127,  ERR_NONE, 0, 1'b1);
    run_string(36, str2q("zz"),   64'd1295, ERR_NONE, 0, 1'b1);
    run_string(36, str2q("Zz"),   64'd1295, ERR_NONE, 0, 1'b1);
    run_string(16, str2q("G1"),   64'd0,    ERR_CHAR, 1, 1'b0);
    run_string(1,  str2q(""),     64'd0,    ERR_BASE, 2, 1'b0);
    run_string(0,  str2q(""),     64'd0,    ERR_BASE, 0, 1'b0);
    run_string(37, str2q(""),     64'd0,    ERR_BASE, 0, 1'b1);
    run_string(16, str2q("100000000"), 64'd0, ERR_OVF, 0, 1'b0);
    run_string(10, str2q("00000000000000000"), 64'd0, ERR_LONG, 0, 1'b0);
    run_string(10, str2q("0000000000000000"),  64'd0, ERR_NONE, 0, 1'b0);
    run_string(10, str2q("99"),   64'd99,   ERR_NONE, 5, 1'b0);
    run_string(10, str2q("4294967296"), 64'd0, ERR_OVF, 0, 1'b0);
    run_string(10, str2q("-"),    64'd0,    ERR_CHAR, 0, 1'b0);
`ifdef RADIX_CONV_SIGN_EN
    run_string(10, str2q("4294967295"),  64'd0,          ERR_OVF,  0, 1'b0);
    run_string(10, str2q("-5"),          64'hFFFFFFFB,   ERR_NONE, 0, 1'b0);
    run_string(10, str2q("-2147483648"), 64'h80000000,   ERR_NONE, 0, 1'b0);
    run_string(10, str2q("2147483648"),  64'd0,          ERR_OVF,  0, 1'b0);
    run_string(10, str2q("-2147483649"), 64'd0,          ERR_OVF,  0, 1'b0);
`else
    run_string(10, str2q("4294967295"),  64'hFFFFFFFF,   ERR_NONE, 0, 1'b0);
    run_string(10, str2q("-5"),          64'd0,          ERR_CHAR, 0, 1'b0);
    run_string(10, str2q("2147483648"),  64'h80000000,   ERR_NONE, 0, 1'b0);
`endif

    // Reset in the middle of a string drops it; the next string converts cleanly.
    start   = 1'b1;
    base_in = 6'd10;
    @(negedge clk);
    start    = 1'b0;
    ch_valid = 1'b1;
    ch_data  = "1";
    @(negedge clk);
    ch_data  = "2";
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_ch_ready", ch_ready, 0);
    check("midrst_res_valid", res_valid, 0);
    check("midrst_res_value", res_value, 0);
    check("midrst_res_err", res_err, 0);
    check("midrst_busy", busy, 0);
    ch_valid = 1'b0;
    ch_data  = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_string(10, str2q("42"), 64'd42, ERR_NONE, 0, 1'b0);

    for (int it = 0; it < 150; it++) begin
      b = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 63) : $urandom_range(2, 36);
      run_model(b, gen((b >= 2 && b <= 36) ? b : 10), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/radix_stream_to_binary.md
Name: radix_stream_to_binary

Overview:
Sequential successor to the combinational any-base-to-decimal converter. It accepts an ASCII digit string one character per cycle over a valid/ready stream and accumulates the value MSB-first in a base selected at run time (2..36). It emits one binary result with an error code per string. It sits between a character source (UART/text front-end) and numeric consumers; width and maximum digit count are parametrised.

Parameters:
VAL_W, 32, result width in bits (8..64).
MAX_DIGITS, 16, maximum characters per string; one more raises ERR_LONG.
CNT_W, $clog2(MAX_DIGITS+2), digit-counter width (derived; do not override).

Ports:
clk  in  1  rising-edge clock.
rst_n  in  1  asynchronous active-low reset.
start  in  1  begin a new string; base_in is sampled on this cycle; ignored unless IDLE.
base_in  in  6  radix, legal 2..36.
ch_valid  in  1  character beat valid.
ch_data  in  8  ASCII character.
ch_last  in  1  marks the final character of the string.
ch_ready  out  1  converter accepts a character this cycle.
res_valid  out  1  result available.
res_value  out  VAL_W  converted value; 0 whenever res_err != ERR_NONE.
res_err  out  3  error code (package enum).
res_ready  in  1  consumer accepts the result.
busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async assert, sync deassert). State=IDLE, acc=0, count=0, err=ERR_NONE, base_q=0. Outputs: ch_ready=0, res_valid=0, res_value=0, res_err=0, busy=0. Reset mid-string drops the partial result and emits no output.
- FSM states: IDLE, ACCUM, DONE.
- IDLE:
  - start=1 latches base_q=base_in and clears acc/count/err.
  - If base_in<2 or base_in>36: go to DONE with ERR_BASE. No character is accepted.
  - Otherwise go to ACCUM.
- ACCUM:
  - ch_ready=1. A beat transfers when ch_valid & ch_ready.
  - Digit decode: '0'-'9' gives 0-9; 'A'-'Z' and 'a'-'z' give 10-35; any other character, or a digit >= base_q, is invalid.
  - Invalid character sets sticky ERR_CHAR. The accumulator holds, and remaining beats are still consumed up to ch_last.
  - Valid digit: next = acc*base_q + digit, computed at VAL_W+6 bits. Any nonzero bit above VAL_W-1 sets sticky ERR_OVF. acc takes the low VAL_W bits.
  - count increments on every beat. When count reaches MAX_DIGITS+1, sticky ERR_LONG is set.
  - On a transferred beat with ch_last=1: go to DONE.
- Latency: res_valid asserts the cycle after the last beat transfers; single-character strings behave the same.
- Error priority, single code reported: ERR_BASE > ERR_CHAR > ERR_LONG > ERR_OVF.
- DONE:
  - res_valid=1. res_value and res_err stay stable until res_valid & res_ready.
  - On that handshake go to IDLE, also in the same cycle.
  - start is ignored in DONE and ACCUM.
  - A new start is honoured from the cycle after returning to IDLE.
- ch_valid outside ACCUM is ignored (ch_ready=0). The producer must hold data until ready.

Optional Feature:
RADIX_CONV_SIGN_EN. When defined, the first beat of a string may be '-'. That beat sets a sign flag, adds no digit and does not count toward MAX_DIGITS. The final value is the two's-complement negation of the magnitude. ERR_OVF triggers if magnitude > 2^(VAL_W-1) for negative strings or > 2^(VAL_W-1)-1 for positive ones. A lone '-' gives ERR_CHAR. When undefined, '-' is an ordinary invalid character (ERR_CHAR), and results are unsigned over the full VAL_W range.

Decomposition:
- Package radix_conv_pkg:
  - state enum.
  - res_err enum: ERR_NONE=0, ERR_BASE=1, ERR_CHAR=2, ERR_LONG=3, ERR_OVF=4.
  - Constants MIN_BASE=2, MAX_BASE=36, and ASCII boundaries ('0','9','A','Z','a','z','-').
- Sub-module radix_digit_decode (combinational): ch_data and base in; digit[5:0] and digit_ok out. It is reused by the planned binary-to-radix block's self-check.

Test Plan:
- base=2, "1010", ch_last on '0' -> res_value=10, ERR_NONE, res_valid exactly one cycle after the last beat.
- base=16, "7F" then base=36, "zz" (lowercase) -> 127 then 1295, both ERR_NONE; back-to-back strings with res_ready held high.
- base=16, "G1" -> ERR_CHAR, res_value=0, both beats consumed; base=1, start -> ERR_BASE in DONE, ch_ready never high.
- VAL_W=32, base=16, "100000000" -> ERR_OVF; with MAX_DIGITS=16, 17 '0' chars -> ERR_LONG.
- res_ready low for 5 cycles in DONE -> res_value/res_err stable and start ignored; rst_n pulsed mid-string -> all outputs 0, next string converts correctly.
- With RADIX_CONV_SIGN_EN, base=10, VAL_W=8: "-128" -> 0x80, ERR_NONE; "128" -> ERR_OVF; "-" -> ERR_CHAR.
